// File: rtl/i2c_codec_responder_pkg.sv
// Shared definitions for the I2C codec register responder: FSM states,
// register-file geometry and the power-on register defaults table.
package i2c_codec_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_ACK_A  = 3'd2,
    ST_HI     = 3'd3,
    ST_ACK_H  = 3'd4,
    ST_LO     = 3'd5,
    ST_ACK_L  = 3'd6,
    ST_IGNORE = 3'd7
  } state_e;

  localparam int         NUM_REGS      = 10;
  localparam logic [6:0] REG_RESET_IDX = 7'd15;

  // Default contents of the codec register file, indexed 0..NUM_REGS-1.
  function automatic logic [8:0] reg_default(input logic [3:0] idx);
    logic [8:0] val;
    case (idx)
      4'd0:    val = 9'h097;
      4'd1:    val = 9'h097;
      4'd2:    val = 9'h079;
      4'd3:    val = 9'h079;
      4'd4:    val = 9'h00A;
      4'd5:    val = 9'h008;
      4'd6:    val = 9'h09F;
      4'd7:    val = 9'h00A;
      4'd8:    val = 9'h000;
      4'd9:    val = 9'h000;
      default: val = 9'h000;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/i2c_codec_responder_edge_detect.sv
// Synchronizes the raw SCL/SDA pins into the clk domain and derives
// single-clk pulses for SCL rise/fall and the START/STOP bus conditions.
module i2c_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  // Synchronizer chains preset to the idle-bus level, plus one history flop each.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q[0] <= scl_i;
      sda_sync_q[0] <= sda_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_sync_q[i] <= scl_sync_q[i-1];
        sda_sync_q[i] <= sda_sync_q[i-1];
      end
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // SDA may only move while SCL is low, so an SDA edge with SCL held high is a bus condition.
  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_codec_responder.sv
// Write-only I2C responder for a codec-style register file: accepts
// address + (HI, LO) word pairs, ACKs them, and updates a small register file.
module i2c_codec_responder
  import i2c_codec_responder_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_sclk,
  input  logic       i2c_sdat_in,
  output logic       sdat_pull_low,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  input  logic [3:0] rd_index,
  output logic [8:0] rd_value,
  output logic [7:0] frame_count,
  output logic       nack_seen
);

  logic       sda_s;
  logic       scl_rise_s;
  logic       scl_fall_s;
  logic       start_s;
  logic       stop_s;

  state_e     state_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic [7:0] hi_q;
  logic       ack_drive_q;
  logic       pull_low_q;
  logic       wr_valid_q;
  logic [6:0] wr_addr_q;
  logic [8:0] wr_data_q;
  logic [7:0] frame_count_q;
  logic       nack_seen_q;
  logic [8:0] regs_q [NUM_REGS];
  logic [7:0] byte_d;

  i2c_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clk        (clk),
    .reset      (reset),
    .scl_i      (i2c_sclk),
    .sda_i      (i2c_sdat_in),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise_s),
    .scl_fall_o (scl_fall_s),
    .start_o    (start_s),
    .stop_o     (stop_s)
  );

  // The byte as it will stand once the current SCL-rise sample is shifted in.
  assign byte_d = {shift_q, sda_s};

  // Protocol FSM: STOP beats START beats per-state bit handling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      hi_q        <= 8'd0;
      ack_drive_q <= 1'b0;
      pull_low_q  <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= 7'd0;
      wr_data_q   <= 9'd0;
      nack_seen_q <= 1'b0;
    end else begin
      wr_valid_q <= 1'b0;
      if (stop_s) begin
        state_q     <= ST_IDLE;
        bit_cnt_q   <= 3'd0;
        ack_drive_q <= 1'b0;
        pull_low_q  <= 1'b0;
      end else if (start_s) begin
        state_q     <= ST_ADDR;
        bit_cnt_q   <= 3'd0;
        ack_drive_q <= 1'b0;
        pull_low_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_ADDR, ST_HI, ST_LO: begin
            if (scl_rise_s) begin
              shift_q   <= byte_d[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (state_q == ST_ADDR) begin
                  if ((byte_d[7:1] == DEV_ADDR) && (byte_d[0] == 1'b0)) begin
                    state_q <= ST_ACK_A;
                  end else begin
                    state_q     <= ST_IGNORE;
                    nack_seen_q <= 1'b1;
                  end
                end else if (state_q == ST_HI) begin
                  hi_q    <= byte_d;
                  state_q <= ST_ACK_H;
                end else begin
                  wr_valid_q <= 1'b1;
                  wr_addr_q  <= hi_q[7:1];
                  wr_data_q  <= {hi_q[0], byte_d};
                  state_q    <= ST_ACK_L;
                end
              end
            end
          end
          ST_ACK_A, ST_ACK_H, ST_ACK_L: begin
            // First fall after bit 8 starts the ACK slot, the next fall ends it.
            if (scl_fall_s) begin
              if (!ack_drive_q) begin
                ack_drive_q <= 1'b1;
                pull_low_q  <= 1'b1;
              end else begin
                ack_drive_q <= 1'b0;
                pull_low_q  <= 1'b0;
                state_q     <= (state_q == ST_ACK_H) ? ST_LO : ST_HI;
              end
            end
          end
          ST_IDLE, ST_IGNORE: begin
            pull_low_q <= 1'b0;
          end
          default: begin
            state_q    <= ST_IDLE;
            pull_low_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Register file and word counter, updated one clk after each accepted word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count_q <= 8'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= reg_default(4'(i));
      end
    end else if (wr_valid_q) begin
      frame_count_q <= frame_count_q + 8'd1;
      if (wr_addr_q <= 7'd9) begin
        regs_q[wr_addr_q[3:0]] <= wr_data_q;
      end else if (wr_addr_q == REG_RESET_IDX) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          regs_q[i] <= reg_default(4'(i));
        end
      end else begin
        frame_count_q <= frame_count_q + 8'd1;
      end
    end else begin
      frame_count_q <= frame_count_q;
    end
  end

  // Readback mux; indices past the register file read as zero.
  always_comb begin
    rd_value = 9'd0;
    if (rd_index <= 4'd9) begin
      rd_value = regs_q[rd_index];
    end else begin
      rd_value = 9'd0;
    end
  end

  assign sdat_pull_low = pull_low_q;
  assign wr_valid      = wr_valid_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign frame_count   = frame_count_q;
  assign nack_seen     = nack_seen_q;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed bench for i2c_codec_responder: an I2C initiator model drives
// transactions, a word-level scoreboard predicts the register file.
module tb_i2c_codec_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [3:0] rd_index = 4'd0;
  logic       sdat_pull_low;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic [8:0] rd_value;
  logic [7:0] frame_count;
  logic       nack_seen;
  wire        sda_pin = sda_m & ~sdat_pull_low;

  int total = 0;
  int bad = 0;
  int q_clk = 25;

  typedef struct {
    logic [6:0] a;
    logic [8:0] d;
  } wr_t;
  wr_t exp_q[$];

  logic [8:0] dflt_tab [10] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                               9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
  logic [8:0] m_regs [10];
  int         m_fc = 0;
  logic       prev_wv = 1'b0;

  i2c_codec_responder #(
    .DEV_ADDR   (7'h1A),
    .SYNC_STAGES(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i2c_sclk     (scl_m),
    .i2c_sdat_in  (sda_pin),
    .sdat_pull_low(sdat_pull_low),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_index     (rd_index),
    .rd_value     (rd_value),
    .frame_count  (frame_count),
    .nack_seen    (nack_seen)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start();
    scl_m = 1'b0; wait_clks(q_clk);
    sda_m = 1'b1; wait_clks(q_clk);
    scl_m = 1'b1; wait_clks(q_clk);
    sda_m = 1'b0; wait_clks(q_clk);
  endtask

  task automatic i2c_stop();
    scl_m = 1'b0; wait_clks(q_clk);
    sda_m = 1'b0; wait_clks(q_clk);
    scl_m = 1'b1; wait_clks(q_clk);
    sda_m = 1'b1; wait_clks(q_clk);
  endtask

  task automatic send_bit(input logic b);
    scl_m = 1'b0; wait_clks(q_clk);
    sda_m = b;    wait_clks(q_clk);
    scl_m = 1'b1; wait_clks(q_clk);
    if (b) chk("sda_released", 32'(sda_pin), 32'd1);
    wait_clks(q_clk);
  endtask

  // Eight data bits MSB first, then the ninth clock with SDA released.
  task automatic send_byte(input logic [7:0] v, input logic exp_ack);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    scl_m = 1'b0; wait_clks(q_clk);
    sda_m = 1'b1; wait_clks(q_clk);
    scl_m = 1'b1; wait_clks(q_clk);
    chk(exp_ack ? "ack" : "no_ack", 32'(sda_pin), exp_ack ? 32'd0 : 32'd1);
    wait_clks(q_clk);
  endtask

  task automatic check_reg(input logic [3:0] idx, input logic [8:0] exp, input string nm);
    int n = 0;
    @(negedge clk);
    while (rd_index !== idx && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_wait"}, 32'(n < 40), 32'd1);
    chk(nm, 32'(rd_value), 32'(exp));
  endtask

  // Readback select sweeps every index so the scoreboard sees the whole file.
  initial begin
    forever begin
      @(posedge clk);
      rd_index = rd_index + 4'd1;
    end
  end

  // Scoreboard: word-level model of the register file and counter.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 10; i++) m_regs[i] = dflt_tab[i];
      m_fc    = 0;
      prev_wv = 1'b0;
    end else begin
      chk("frame_count", 32'(frame_count), 32'(8'(m_fc)));
      chk("rd_value", 32'(rd_value), (rd_index <= 4'd9) ? 32'(m_regs[rd_index]) : 32'd0);
      if (wr_valid) begin
        chk("wr_valid_width", 32'(prev_wv), 32'd0);
        chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.a));
          chk("wr_data", 32'(wr_data), 32'(e.d));
          m_fc = (m_fc + 1) % 256;
          if (e.a <= 7'd9) m_regs[e.a] = e.d;
          else if (e.a == 7'd15) for (int i = 0; i < 10; i++) m_regs[i] = dflt_tab[i];
        end
      end
      prev_wv = wr_valid;
    end
  end

  initial begin
    // Reset state
    wait_clks(5);
    @(negedge clk);
    chk("rst_pull", 32'(sdat_pull_low), 32'd0);
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);
    chk("rst_nack", 32'(nack_seen), 32'd0);
    check_reg(4'd0, 9'h097, "rst_reg0");
    check_reg(4'd12, 9'h000, "rst_reg12");
    @(posedge clk);
    reset = 1'b0;
    wait_clks(10);

    // Defaults reload word at 100 kHz
    q_clk = 125;
    i2c_start();
    send_byte(8'h34, 1'b1);
    send_byte(8'h1E, 1'b1);
    exp_q.push_back('{7'h0F, 9'h000});
    send_byte(8'h00, 1'b1);
    i2c_stop();
    wait_clks(10);
    chk("s1_fc", 32'(frame_count), 32'd1);
    chk("s1_addr", 32'(wr_addr), 32'h0F);
    chk("s1_data", 32'(wr_data), 32'h000);
    chk("s1_left", 32'(exp_q.size()), 32'd0);
    check_reg(4'd6, 9'h09F, "s1_reg6");
    q_clk = 25;

    // Plain store to register 4
    i2c_start();
    send_byte(8'h34, 1'b1);
    send_byte(8'h08, 1'b1);
    exp_q.push_back('{7'h04, 9'h015});
    send_byte(8'h15, 1'b1);
    i2c_stop();
    wait_clks(10);
    chk("s2_addr", 32'(wr_addr), 32'h04);
    chk("s2_data", 32'(wr_data), 32'h015);
    chk("s2_model", 32'(m_regs[4]), 32'h015);
    check_reg(4'd4, 9'h015, "s2_reg4");

    // Foreign address is ignored
    i2c_start();
    send_byte(8'h36, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h15, 1'b0);
    i2c_stop();
    wait_clks(10);
    chk("s3_nack", 32'(nack_seen), 32'd1);
    chk("s3_fc", 32'(frame_count), 32'd2);

    // STOP in the middle of the LO byte, then clocking without START
    i2c_start();
    send_byte(8'h34, 1'b1);
    send_byte(8'h0C, 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    i2c_stop();
    wait_clks(10);
    chk("s4_pull", 32'(sdat_pull_low), 32'd0);
    chk("s4_fc", 32'(frame_count), 32'd2);
    send_byte(8'h34, 1'b0);
    i2c_stop();

    // Two words in one transaction
    i2c_start();
    send_byte(8'h34, 1'b1);
    send_byte(8'h0E, 1'b1);
    exp_q.push_back('{7'h07, 9'h053});
    send_byte(8'h53, 1'b1);
    send_byte(8'h10, 1'b1);
    exp_q.push_back('{7'h08, 9'h001});
    send_byte(8'h01, 1'b1);
    i2c_stop();
    wait_clks(10);
    chk("s5_fc", 32'(frame_count), 32'd4);
    check_reg(4'd7, 9'h053, "s5_reg7");
    check_reg(4'd8, 9'h001, "s5_reg8");

    // Highest stored index and first unstored index
    i2c_start();
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    exp_q.push_back('{7'h09, 9'h0FF});
    send_byte(8'hFF, 1'b1);
    send_byte(8'h14, 1'b1);
    exp_q.push_back('{7'h0A, 9'h0FF});
    send_byte(8'hFF, 1'b1);
    i2c_stop();
    wait_clks(10);
    chk("s6_fc", 32'(frame_count), 32'd6);
    check_reg(4'd9, 9'h0FF, "s6_reg9");
    check_reg(4'd10, 9'h000, "s6_reg10");

    // Defaults reload after modifications
    i2c_start();
    send_byte(8'h34, 1'b1);
    send_byte(8'h1E, 1'b1);
    exp_q.push_back('{7'h0F, 9'h000});
    send_byte(8'h00, 1'b1);
    i2c_stop();
    wait_clks(10);
    chk("s7_fc", 32'(frame_count), 32'd7);
    check_reg(4'd4, 9'h097 & 9'h00A | 9'h00A, "s7_reg4");
    check_reg(4'd9, 9'h000, "s7_reg9");

    // Reset pulse during the HI byte, then a full write
    i2c_start();
    send_byte(8'h34, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    scl_m = 1'b0;
    wait_clks(3);
    reset = 1'b1;
    wait_clks(5);
    reset = 1'b0;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    i2c_stop();
    wait_clks(10);
    chk("s8_fc0", 32'(frame_count), 32'd0);
    chk("s8_nack0", 32'(nack_seen), 32'd0);
    i2c_start();
    send_byte(8'h34, 1'b1);
    send_byte(8'h02, 1'b1);
    exp_q.push_back('{7'h01, 9'h0AB});
    send_byte(8'hAB, 1'b1);
    i2c_stop();
    wait_clks(10);
    chk("s8_fc", 32'(frame_count), 32'd1);
    check_reg(4'd1, 9'h0AB, "s8_reg1");

    // Read request is refused
    i2c_start();
    send_byte(8'h35, 1'b0);
    i2c_stop();
    wait_clks(10);
    chk("s9_nack", 32'(nack_seen), 32'd1);
    chk("end_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
